// File: rtl/datapath_pkg.sv
// Shared datapath constants and the decoded stack-operation type used by link_stack.
package datapath_pkg;

  localparam int PC_WIDTH   = 16;
  localparam int OVF_REJECT = 0;
  localparam int OVF_WRAP   = 1;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_FLUSH,
    OP_REPLACE,
    OP_PUSH,
    OP_WRAP,
    OP_POP
  } stack_op_e;

endpackage

// File: rtl/link_stack.sv
// Return-address stack beside the PC: JAL commit pushes, JR-via-link commit pops,
// and top_addr feeds the PC new-address mux combinationally from registered state.
module link_stack
  import datapath_pkg::*;
#(
  parameter int ADDR_WIDTH = PC_WIDTH,
  parameter int DEPTH      = 8,
  parameter int OVF_MODE   = OVF_REJECT
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [ADDR_WIDTH-1:0]      push_addr,
  input  logic                       pop,
  input  logic                       flush,
  input  logic                       clear_flags,
  output logic [ADDR_WIDTH-1:0]      top_addr,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int SP_W  = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [SP_W-1:0]  SP_LAST  = SP_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  generate
    if (DEPTH < 2 || DEPTH > 64) begin : g_bad_depth
      $error("link_stack: DEPTH must be in the range 2 to 64");
    end
  endgenerate

  logic [ADDR_WIDTH-1:0] r_mem [DEPTH];
  logic [SP_W-1:0]       r_sp;
  logic [CNT_W-1:0]      r_count;
  logic                  r_ovf;
  logic                  r_unf;

  logic [SP_W-1:0] w_sp_inc;
  logic [SP_W-1:0] w_sp_dec;
  logic            w_empty;
  logic            w_full;
  logic            w_set_ovf;
  logic            w_set_unf;
  stack_op_e       w_op;

  // Pointers wrap explicitly because DEPTH need not be a power of two.
  assign w_sp_inc = (r_sp == SP_LAST) ? '0 : r_sp + SP_W'(1);
  assign w_sp_dec = (r_sp == '0) ? SP_LAST : r_sp - SP_W'(1);
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CNT_FULL);

  // push, pop and flush are single-cycle strobes with no handshake: the request
  // present at a rising edge is always accepted and takes effect at that edge.
  always_comb begin
    w_op = OP_IDLE;
    if (flush) begin
      w_op = OP_FLUSH;
    end else if (push && pop && !w_empty) begin
      w_op = OP_REPLACE;
    end else if (push) begin
      if (!w_full)                   w_op = OP_PUSH;
      else if (OVF_MODE == OVF_WRAP) w_op = OP_WRAP;
      else                           w_op = OP_IDLE;
    end else if (pop && !w_empty) begin
      w_op = OP_POP;
    end
  end

  assign w_set_ovf = !flush && push && !pop && w_full;
  assign w_set_unf = !flush && pop && w_empty;

  // Storage is intentionally not reset; count gates every read.
  always_ff @(posedge clock) begin
    case (w_op)
      OP_REPLACE:       r_mem[w_sp_dec] <= push_addr;
      OP_PUSH, OP_WRAP: r_mem[r_sp]     <= push_addr;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      case (w_op)
        OP_FLUSH: begin
          r_sp    <= '0;
          r_count <= '0;
        end
        OP_PUSH: begin
          r_sp    <= w_sp_inc;
          r_count <= r_count + CNT_W'(1);
        end
        OP_WRAP: r_sp <= w_sp_inc;
        OP_POP: begin
          r_sp    <= w_sp_dec;
          r_count <= r_count - CNT_W'(1);
        end
        default: ;
      endcase
      r_ovf <= w_set_ovf | (r_ovf & ~clear_flags);
      r_unf <= w_set_unf | (r_unf & ~clear_flags);
    end
  end

  assign top_addr  = w_empty ? '0 : r_mem[w_sp_dec];
  assign valid     = !w_empty;
  assign full      = w_full;
  assign count     = r_count;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule

// File: tb/tb_link_stack.sv
// Bench for link_stack: three configurations share one stimulus stream and are
// compared every cycle against a queue-based model of a return-address stack.
module tb_link_stack;
  import datapath_pkg::*;

  logic        clock;
  logic        reset;
  logic        push;
  logic [15:0] push_addr;
  logic        pop;
  logic        flush;
  logic        clear_flags;

  logic [15:0] top_d8, top_d4, top_d5;
  logic        valid_d8, valid_d4, valid_d5;
  logic        full_d8, full_d4, full_d5;
  logic [3:0]  cnt_d8;
  logic [2:0]  cnt_d4, cnt_d5;
  logic        ovf_d8, ovf_d4, ovf_d5;
  logic        unf_d8, unf_d4, unf_d5;

  link_stack #(.ADDR_WIDTH(16), .DEPTH(8), .OVF_MODE(OVF_REJECT)) u_d8 (
    .clock(clock), .reset(reset), .push(push), .push_addr(push_addr), .pop(pop),
    .flush(flush), .clear_flags(clear_flags), .top_addr(top_d8), .valid(valid_d8),
    .full(full_d8), .count(cnt_d8), .overflow(ovf_d8), .underflow(unf_d8)
  );

  link_stack #(.ADDR_WIDTH(16), .DEPTH(4), .OVF_MODE(OVF_REJECT)) u_d4 (
    .clock(clock), .reset(reset), .push(push), .push_addr(push_addr), .pop(pop),
    .flush(flush), .clear_flags(clear_flags), .top_addr(top_d4), .valid(valid_d4),
    .full(full_d4), .count(cnt_d4), .overflow(ovf_d4), .underflow(unf_d4)
  );

  link_stack #(.ADDR_WIDTH(16), .DEPTH(5), .OVF_MODE(OVF_WRAP)) u_d5 (
    .clock(clock), .reset(reset), .push(push), .push_addr(push_addr), .pop(pop),
    .flush(flush), .clear_flags(clear_flags), .top_addr(top_d5), .valid(valid_d5),
    .full(full_d5), .count(cnt_d5), .overflow(ovf_d5), .underflow(unf_d5)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // scoreboard: one expected stack per instance, back of the queue is the top
  logic [15:0] exp_q [3][$];
  logic        exp_ovf [3];
  logic        exp_unf [3];
  int          n_checks;
  int          n_errors;

  function automatic int depth_of(input int i);
    case (i)
      0:       return 8;
      1:       return 4;
      default: return 5;
    endcase
  endfunction

  function automatic bit wraps(input int i);
    return (i == 2);
  endfunction

  function automatic string name_of(input int i);
    case (i)
      0:       return "d8";
      1:       return "d4";
      default: return "d5w";
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int i, input bit p, input logic [15:0] a,
                            input bit q, input bit f, input bit c);
    int n;
    bit set_o;
    bit set_u;
    n     = exp_q[i].size();
    set_o = 1'b0;
    set_u = 1'b0;
    if (f) begin
      exp_q[i].delete();
    end else if (p && q) begin
      if (n > 0) exp_q[i][n-1] = a;
      else begin
        exp_q[i].push_back(a);
        set_u = 1'b1;
      end
    end else if (p) begin
      if (n < depth_of(i)) exp_q[i].push_back(a);
      else begin
        set_o = 1'b1;
        if (wraps(i)) begin
          void'(exp_q[i].pop_front());
          exp_q[i].push_back(a);
        end
      end
    end else if (q) begin
      if (n > 0) void'(exp_q[i].pop_back());
      else set_u = 1'b1;
    end
    exp_ovf[i] = set_o | (exp_ovf[i] & !c);
    exp_unf[i] = set_u | (exp_unf[i] & !c);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      exp_q[i].delete();
      exp_ovf[i] = 1'b0;
      exp_unf[i] = 1'b0;
    end
  endtask

  task automatic check_inst(input int i);
    logic [31:0] o_top;
    logic [31:0] o_cnt;
    logic        o_v, o_f, o_o, o_u;
    int          n;
    string       nm;
    case (i)
      0: begin o_top = {16'h0, top_d8}; o_cnt = {28'h0, cnt_d8}; o_v = valid_d8; o_f = full_d8; o_o = ovf_d8; o_u = unf_d8; end
      1: begin o_top = {16'h0, top_d4}; o_cnt = {29'h0, cnt_d4}; o_v = valid_d4; o_f = full_d4; o_o = ovf_d4; o_u = unf_d4; end
      default: begin o_top = {16'h0, top_d5}; o_cnt = {29'h0, cnt_d5}; o_v = valid_d5; o_f = full_d5; o_o = ovf_d5; o_u = unf_d5; end
    endcase
    n  = exp_q[i].size();
    nm = name_of(i);
    check({nm, ".count"}, o_cnt, n);
    check({nm, ".top"}, o_top, (n > 0) ? {16'h0, exp_q[i][n-1]} : 32'h0);
    check({nm, ".valid"}, {31'h0, o_v}, {31'h0, n > 0});
    check({nm, ".full"}, {31'h0, o_f}, {31'h0, n == depth_of(i)});
    check({nm, ".overflow"}, {31'h0, o_o}, {31'h0, exp_ovf[i]});
    check({nm, ".underflow"}, {31'h0, o_u}, {31'h0, exp_unf[i]});
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) check_inst(i);
  endtask

  // driver: called at a falling edge; applies one cycle and checks after the edge
  task automatic do_cycle(input bit p, input logic [15:0] a, input bit q,
                          input bit f, input bit c);
    push = p; push_addr = a; pop = q; flush = f; clear_flags = c;
    for (int i = 0; i < 3; i++) model_step(i, p, a, q, f, c);
    @(posedge clock);
    @(negedge clock);
    check_all();
    push = 1'b0; push_addr = 16'h0; pop = 1'b0; flush = 1'b0; clear_flags = 1'b0;
  endtask

  task automatic clean();
    do_cycle(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic async_reset_check();
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    check("async.count_d8", {28'h0, cnt_d8}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int bias;
    bit p, q, f, c;
    n_checks = 0;
    n_errors = 0;
    push = 1'b0; push_addr = 16'h0; pop = 1'b0; flush = 1'b0; clear_flags = 1'b0;
    reset = 1'b1;
    model_reset();
    #2;
    check_all();
    @(negedge clock);
    reset = 1'b0;
    do_cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

    // ordered push then pop
    do_cycle(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
    do_cycle(1'b1, 16'h0020, 1'b0, 1'b0, 1'b0);
    do_cycle(1'b1, 16'h0030, 1'b0, 1'b0, 1'b0);
    check("plan.top30", {16'h0, top_d8}, 32'h0030);
    for (int k = 0; k < 3; k++) do_cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    check("plan.unf_stays0", {31'h0, unf_d8}, 32'h0);

    // fill past capacity: reject on depth 4, wrap on depth 5
    clean();
    for (int k = 1; k <= 7; k++) do_cycle(1'b1, 16'(k), 1'b0, 1'b0, 1'b0);
    check("plan.d4_top", {16'h0, top_d4}, 32'h4);
    check("plan.d5_top", {16'h0, top_d5}, 32'h7);
    check("plan.d5_count", {29'h0, cnt_d5}, 32'h5);
    for (int k = 0; k < 8; k++) do_cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);

    // push with pop together
    clean();
    do_cycle(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0);
    do_cycle(1'b1, 16'hBBBB, 1'b1, 1'b0, 1'b0);
    check("plan.replace_top", {16'h0, top_d8}, 32'hBBBB);
    clean();
    do_cycle(1'b1, 16'hCCCC, 1'b1, 1'b0, 1'b0);
    check("plan.empty_pp_unf", {31'h0, unf_d8}, 32'h1);

    // flush beats push; set beats clear
    clean();
    for (int k = 0; k < 3; k++) do_cycle(1'b1, 16'(16'h100 + k), 1'b0, 1'b0, 1'b0);
    do_cycle(1'b1, 16'h0999, 1'b0, 1'b1, 1'b0);
    do_cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    check("plan.set_wins", {31'h0, unf_d5}, 32'h1);

    // back-to-back push, push, pop then asynchronous reset with live entries
    do_cycle(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    do_cycle(1'b1, 16'h5678, 1'b0, 1'b0, 1'b0);
    do_cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    do_cycle(1'b1, 16'h9ABC, 1'b0, 1'b0, 1'b0);
    async_reset_check();
    do_cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

    // randomized traffic with alternating fill / drain bias
    for (int k = 0; k < 3000; k++) begin
      bias = (k / 150) % 2;
      p = ($urandom_range(0, 9) < ((bias == 1) ? 7 : 3));
      q = ($urandom_range(0, 9) < ((bias == 1) ? 3 : 7));
      f = ($urandom_range(0, 63) == 0);
      c = ($urandom_range(0, 15) == 0);
      do_cycle(p, 16'($urandom), q, f, c);
      if ($urandom_range(0, 999) == 0) async_reset_check();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/link_stack.md
# link_stack

Parametrised hardware return-address stack for the 16-bit datapath, holding the addresses that JAL-type instructions link to and supplying them on return. It sits beside the program counter. Push is driven when a JAL commits; pop is driven when a return (JR via link) commits. The top entry feeds the PC's new-address mux. It generalises the single link register to a configurable depth, width and overflow policy, and adds status, sticky error flags and flush.

## Interface
Parameters:
- ADDR_WIDTH, 16: width of each stored return address.
- DEPTH, 8: number of entries; legal values are 2 to 64, and the value need not be a power of two.
- OVF_MODE, 0: full-stack policy. 0 = REJECT: a push when full is dropped. 1 = WRAP: a push when full overwrites the oldest entry.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- push  in  1  store push_addr as the new top this cycle.
- push_addr  in  ADDR_WIDTH  return address to store (PC+1 of the JAL).
- pop  in  1  remove the top entry this cycle.
- flush  in  1  synchronous empty (pipeline or exception redirect); has priority over push and pop.
- clear_flags  in  1  synchronous clear of overflow and underflow.
- top_addr  out  ADDR_WIDTH  current top entry; 0 when empty.
- valid  out  1  stack non-empty.
- full  out  1  count == DEPTH.
- count  out  $clog2(DEPTH+1)  number of live entries.
- overflow  out  1  sticky: a push occurred while full.
- underflow  out  1  sticky: a pop occurred while empty.

## Operation
State:
- storage array mem[DEPTH].
- sp, width $clog2(DEPTH): index of the next free slot.
- count.
- two sticky flags.
- top_addr = mem[(sp-1) mod DEPTH] when count > 0, else 0.
- All pointer arithmetic is explicit modulo DEPTH. Never rely on natural binary wrap, because DEPTH need not be a power of two.

Per-edge priority:
1. flush: sp = 0, count = 0. Memory contents are left unchanged. Flags are left unchanged unless clear_flags is also asserted.
2. push and pop together, count > 0: overwrite mem[sp-1] with push_addr. sp and count are unchanged (return immediately followed by a call).
3. push and pop together, count == 0: behaves as push only, and underflow is set.
4. push only, count < DEPTH: mem[sp] = push_addr; sp++ mod DEPTH; count++.
5. push only, full, REJECT: no state change; overflow is set.
6. push only, full, WRAP: mem[sp] = push_addr; sp++ mod DEPTH; count stays DEPTH; overflow is set. The oldest entry is lost.
7. pop only, count > 0: sp-- mod DEPTH; count--.
8. pop only, count == 0: no change; underflow is set.

Flag rules:
- clear_flags clears both sticky flags.
- If a set condition occurs in the same cycle as clear_flags, the set wins.

## Timing
- Reset values: top_addr = 0, valid = 0, full = 0, count = 0, overflow = 0, underflow = 0, sp = 0. Memory is not reset.
- Reset is asynchronous: outputs go to their reset values immediately, independent of clock. Release is synchronised externally.
- If reset is asserted mid-sequence, all in-flight pushes are lost. After release, the stack is empty.
- Latency: a push or pop sampled at edge N is reflected on top_addr, valid, full and count after edge N.
- top_addr is a combinational read of registered state. It has no input-to-output combinational path from push, pop or push_addr.
- There is no handshake. push and pop are single-cycle strobes, and a new operation is accepted every cycle.
- A back-to-back push, push, pop sequence must be exact: no bubbles and no stale top.

## Structure
- Shared package datapath_pkg holds:
  - localparams OVF_REJECT = 0 and OVF_WRAP = 1.
  - constant PC_WIDTH = 16, used as the default for ADDR_WIDTH.
- The block is a single module with no sub-module.
- Storage is a plain register array. It is not BlockRam, because the top must be readable combinationally in the same cycle.
- Elaboration-time check: DEPTH below 2 or above 64 raises $error.

## Test plan
- Reset then idle: all outputs 0. Assert reset asynchronously mid-cycle after 3 pushes -> count = 0 and valid = 0 before the next edge.
- Push 0x0010, 0x0020, 0x0030, then pop 3 times -> top_addr reads 0x0030, 0x0020, 0x0010, then 0. valid drops after the third pop. underflow stays 0.
- DEPTH=4, REJECT: push 0x1..0x5 -> count = 4, full = 1, top_addr = 0x4, overflow = 1. Then 4 pops -> 0x4, 0x3, 0x2, 0x1.
- DEPTH=5, WRAP: push 0x1..0x7 -> count = 5, overflow = 1. 5 pops yield 0x7, 0x6, 0x5, 0x4, 0x3. A sixth pop sets underflow.
- Push 0xAAAA, then push and pop together with 0xBBBB -> count = 1, top_addr = 0xBBBB. From empty, push and pop together with 0xCCCC -> count = 1, top_addr = 0xCCCC, underflow = 1.
- Push 3 entries, then flush together with push -> count = 0. Then clear_flags in the same cycle as a pop on empty -> underflow = 1 (set wins).
